sd_lane_arbiter: RTL and testbench
==================================

Name: sd_lane_arbiter

Overview:
Shares one HPS virtual-disk request lane between N disk clients: floppy_track drive 1, the HDD block handler and floppy_track drive 2. Each client raises a read or write request with a sector LBA. The arbiter grants clients round-robin, drives a single sd_lba/sd_rd/sd_wr handshake towards hps_io, and routes sd_ack, sd_buff_wr and sd_buff_din to and from the granted client. It sits in emu between the disk controllers and hps_io, and exposes busy for CPU_WAIT gating.

Parameters:
N, 3, number of clients (2..4); client index width CW = 2.
TIMEOUT, 24'd14_000_000, clk_sys cycles to wait for sd_ack rise before aborting (about 1 s at 14 MHz).

Ports:
clk_sys  in  1  system clock (14.3 MHz).
reset_n  in  1  asynchronous, active-low reset.
cl_rd  in  N  per-client read request; level, held until cl_done.
cl_wr  in  N  per-client write request; level, held until cl_done.
cl_lba  in  32*N  per-client sector LBA; client i uses bits [32i+31:32i]; stable while its request is high.
cl_buff_din  in  8*N  per-client write data for sector buffer reads.
cl_ack  out  N  routed sd_ack; only the granted client's bit may be 1.
cl_buff_wr  out  N  routed sd_buff_wr, gated by cl_ack.
cl_done  out  N  1-cycle completion pulse.
cl_err  out  N  1-cycle timeout pulse, coincident with cl_done.
sd_lba  out  32  LBA to hps_io.
sd_rd  out  1  read request to hps_io.
sd_wr  out  1  write request to hps_io.
sd_ack  in  1  hps_io acknowledge; high for the whole sector transfer.
sd_buff_wr  in  1  hps_io buffer write strobe.
sd_buff_din  out  8  cl_buff_din of the granted client; 0 when idle.
busy  out  1  high whenever state != IDLE.
cur  out  CW  granted client index.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; last=N-1, so client 0 wins the first arbitration.
- pend[i] = cl_rd[i] | cl_wr[i].
- IDLE:
  - If any pend bit is set, pick the first set index scanning last+1, last+2, … modulo N.
  - Latch cur, sd_lba=cl_lba[cur] and op. Read wins if cl_rd and cl_wr are both set; the write stays pending for a later grant.
  - Next cycle: state=ISSUE, with sd_rd or sd_wr asserted.
  - Request-to-sd_rd/sd_wr latency: exactly 1 cycle.
- ISSUE:
  - Hold sd_rd/sd_wr and sd_lba.
  - sd_ack rising edge (registered old_ack): clear sd_rd/sd_wr in the same cycle, then go to XFER.
  - Timeout counter reaches TIMEOUT-1: clear sd_rd/sd_wr, pulse cl_done[cur] and cl_err[cur], set last=cur, go to IDLE.
- XFER:
  - cl_ack[cur]=sd_ack and cl_buff_wr[cur]=sd_buff_wr&sd_ack, both combinational (0-cycle routing).
  - sd_buff_din=cl_buff_din[cur].
  - sd_ack falling edge: pulse cl_done[cur] for 1 cycle, set last=cur, go to IDLE.
  - No new grant is made in the cycle cl_done is pulsed, so there is a 1-cycle minimum gap between transfers.
- Routing outside XFER: cl_ack and cl_buff_wr are 0 for every client. The exception is an sd_ack already high on ISSUE entry; its rising edge is still required.
- Client drops its request mid-ISSUE: ignored; the transaction completes normally and cl_done still pulses.
- sd_lba is stable from ISSUE entry until the return to IDLE.
- Timeout counter is 24-bit, cleared on ISSUE entry, and does not run in XFER.
- Fairness: a client that re-requests immediately after cl_done is served after the other pending clients.
- Reset mid-transfer forces IDLE and drops sd_rd/sd_wr. hps_io aborts on its own; the next sd_ack edge seen in IDLE is ignored.

Decomposition:
- Package sd_arb_pkg holds:
  - typedef state_t {IDLE, ISSUE, XFER}
  - op_t {OP_RD, OP_WR}
  - the CW localparam
  - the TIMEOUT default
- One sub-module, rr_pick: combinational round-robin priority encoder with inputs pend[N] and last, and outputs valid and idx.

Test Plan:
1. Single read: cl_rd=3'b001, cl_lba[0]=32'h10. Expect sd_rd high 1 cycle later with sd_lba=32'h10. On sd_ack rise, sd_rd drops. With ack held 512 cycles plus 512 sd_buff_wr, cl_buff_wr[0] toggles 512 times. On ack fall, cl_done=3'b001 for 1 cycle.
2. Simultaneous requests: cl_rd=3'b111 all at once, from reset. Grants run in order 0,1,2; a repeated 0 request is served after 1 and 2; each cl_done is followed by at least 1 idle cycle.
3. Write routing: client 2 cl_wr with cl_buff_din[2]=8'hA5, others 8'h00. Expect sd_wr asserted and sd_buff_din=8'hA5 during XFER, and 8'h00 after returning to IDLE.
4. Rd+wr both set on client 1. Expect a read transaction first, then a write on the next grant of client 1, with cl_done pulsing twice.
5. Timeout with TIMEOUT=16 and sd_ack never rising. Expect sd_rd to drop after 16 ISSUE cycles, cl_err[cur] and cl_done[cur] to pulse together, and busy=0 next cycle.
6. Reset mid-XFER: reset_n low asynchronously. Expect all outputs 0 immediately and cur=0. The next request from client 0 is granted first.

Source files
------------

// File: rtl/sd_lane_arbiter_pkg.sv
// Shared types and constants for the HPS virtual-disk lane arbiter.
package sd_arb_pkg;
   localparam int CW = 2;
   localparam logic [23:0] TIMEOUT_DEFAULT = 24'd14_000_000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      XFER  = 2'd2
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;
endpackage

// File: rtl/sd_lane_arbiter_rr_pick.sv
// Round-robin priority encoder: first pending index after 'last', wrapping modulo N.
module rr_pick
   import sd_arb_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0]  pend,
   input  logic [CW-1:0] last,
   output logic          valid,
   output logic [CW-1:0] idx
);

   logic [CW-1:0] cand;

   // Scan from farthest to nearest so the nearest pending client overwrites the rest.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = N; k >= 1; k--) begin
         cand = CW'((int'(last) + k) % N);
         if (pend[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end else begin
            valid = valid;
            idx   = idx;
         end
      end
   end

endmodule

// File: rtl/sd_lane_arbiter.sv
// Shares one hps_io sd_lba/sd_rd/sd_wr lane between N disk clients, granting round-robin
// and routing sd_ack/sd_buff_wr/sd_buff_din to and from the granted client.
module sd_lane_arbiter
   import sd_arb_pkg::*;
#(
   parameter int          N       = 3,
   parameter logic [23:0] TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic            clk_sys,
   input  logic            reset_n,
   input  logic [N-1:0]    cl_rd,
   input  logic [N-1:0]    cl_wr,
   input  logic [32*N-1:0] cl_lba,
   input  logic [8*N-1:0]  cl_buff_din,
   output logic [N-1:0]    cl_ack,
   output logic [N-1:0]    cl_buff_wr,
   output logic [N-1:0]    cl_done,
   output logic [N-1:0]    cl_err,
   output logic [31:0]     sd_lba,
   output logic            sd_rd,
   output logic            sd_wr,
   input  logic            sd_ack,
   input  logic            sd_buff_wr,
   output logic [7:0]      sd_buff_din,
   output logic            busy,
   output logic [CW-1:0]   cur
);

   state_t        state;
   op_t           op;
   logic [CW-1:0] last;
   logic          old_ack;
   logic [23:0]   tmr;

   logic [N-1:0]  pend;
   logic          pick_valid;
   logic [CW-1:0] pick_idx;
   logic [31:0]   lba_pick;
   logic          ack_rise;
   logic          ack_fall;

   assign pend     = cl_rd | cl_wr;
   assign ack_rise = sd_ack & ~old_ack;
   assign ack_fall = ~sd_ack & old_ack;

   // Request strobes exist only while in ISSUE, so they drop in the cycle the state leaves it.
   assign sd_rd = (state == ISSUE) && (op == OP_RD);
   assign sd_wr = (state == ISSUE) && (op == OP_WR);
   assign busy  = (state != IDLE);

   rr_pick #(.N(N)) u_rr_pick (
      .pend  (pend),
      .last  (last),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // LBA of the client about to be granted.
   always_comb begin
      lba_pick = '0;
      for (int i = 0; i < N; i++) begin
         if (pick_idx == CW'(i)) begin
            lba_pick = cl_lba[32*i +: 32];
         end else begin
            lba_pick = lba_pick;
         end
      end
   end

   // Zero-latency routing of the transfer handshake to/from the granted client.
   always_comb begin
      cl_ack      = '0;
      cl_buff_wr  = '0;
      sd_buff_din = '0;
      if (state == XFER) begin
         cl_ack[cur]     = sd_ack;
         cl_buff_wr[cur] = sd_buff_wr & sd_ack;
         for (int i = 0; i < N; i++) begin
            if (cur == CW'(i)) begin
               sd_buff_din = cl_buff_din[8*i +: 8];
            end else begin
               sd_buff_din = sd_buff_din;
            end
         end
      end else begin
         cl_ack      = '0;
         cl_buff_wr  = '0;
         sd_buff_din = '0;
      end
   end

   // Arbitration FSM; last resets to N-1 so client 0 wins the first grant.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         op      <= OP_RD;
         cur     <= '0;
         last    <= CW'(N - 1);
         old_ack <= 1'b0;
         tmr     <= 24'd0;
         sd_lba  <= 32'd0;
         cl_done <= '0;
         cl_err  <= '0;
      end else begin
         old_ack <= sd_ack;
         cl_done <= '0;
         cl_err  <= '0;
         case (state)
            IDLE: begin
               // A pending cl_done blocks the grant, leaving an idle cycle between transfers.
               if (pick_valid && (cl_done == '0)) begin
                  cur    <= pick_idx;
                  sd_lba <= lba_pick;
                  op     <= cl_rd[pick_idx] ? OP_RD : OP_WR;
                  tmr    <= 24'd0;
                  state  <= ISSUE;
               end else begin
                  state <= IDLE;
               end
            end
            ISSUE: begin
               if (ack_rise) begin
                  state <= XFER;
               end else if (tmr == (TIMEOUT - 24'd1)) begin
                  cl_done[cur] <= 1'b1;
                  cl_err[cur]  <= 1'b1;
                  last         <= cur;
                  state        <= IDLE;
               end else begin
                  tmr <= tmr + 24'd1;
               end
            end
            XFER: begin
               if (ack_fall) begin
                  cl_done[cur] <= 1'b1;
                  last         <= cur;
                  state        <= IDLE;
               end else begin
                  state <= XFER;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_lane_arbiter.sv
// Scoreboard bench for sd_lane_arbiter: the driver queues expected grant/done events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_sd_lane_arbiter;

   localparam int N = 3;

   logic          clk_sys;
   logic          reset_n;
   logic [N-1:0]  cl_rd;
   logic [N-1:0]  cl_wr;
   logic [95:0]   cl_lba;
   logic [23:0]   cl_buff_din;
   logic [N-1:0]  cl_ack;
   logic [N-1:0]  cl_buff_wr;
   logic [N-1:0]  cl_done;
   logic [N-1:0]  cl_err;
   logic [31:0]   sd_lba;
   logic          sd_rd;
   logic          sd_wr;
   logic          sd_ack;
   logic          sd_buff_wr;
   logic [7:0]    sd_buff_din;
   logic          busy;
   logic [1:0]    cur;

   typedef struct {
      bit          done;
      int          client;
      bit          wr;
      logic [31:0] lba;
      bit          err;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;

   sd_lane_arbiter #(.N(N), .TIMEOUT(24'd16)) dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .cl_rd       (cl_rd),
      .cl_wr       (cl_wr),
      .cl_lba      (cl_lba),
      .cl_buff_din (cl_buff_din),
      .cl_ack      (cl_ack),
      .cl_buff_wr  (cl_buff_wr),
      .cl_done     (cl_done),
      .cl_err      (cl_err),
      .sd_lba      (sd_lba),
      .sd_rd       (sd_rd),
      .sd_wr       (sd_wr),
      .sd_ack      (sd_ack),
      .sd_buff_wr  (sd_buff_wr),
      .sd_buff_din (sd_buff_din),
      .busy        (busy),
      .cur         (cur)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endfunction

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic push_grant(input int c, input bit wr, input logic [31:0] lba);
      ev_t e;
      e.done = 1'b0; e.client = c; e.wr = wr; e.lba = lba; e.err = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic push_done(input int c, input bit err);
      ev_t e;
      e.done = 1'b1; e.client = c; e.wr = 1'b0; e.lba = 32'd0; e.err = err;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic wait_grant(output int t);
      t = 0;
      while (!(sd_rd || sd_wr) && t < 50) begin
         tick();
         t++;
      end
      check("grant_wait", 64'(t < 50), 64'd1);
   endtask

   // hps_io side of one sector transfer, then release the finished request bits.
   task automatic hps_xfer(input int c, input int nbytes, input logic [7:0] din,
                           input logic [N-1:0] drop_rd, input logic [N-1:0] drop_wr);
      logic [N-1:0] mask;
      int t;
      int cnt;
      mask = '0;
      mask[c] = 1'b1;
      cnt = 0;
      wait_grant(t);
      tick();
      sd_ack = 1'b1;
      tick();
      check($sformatf("ack_rise_c%0d", c), {sd_rd, sd_wr, busy, cl_ack, sd_buff_din},
            {1'b0, 1'b0, 1'b1, mask, din});
      for (int b = 0; b < nbytes; b++) begin
         sd_buff_wr = 1'b1;
         #1;
         if (cl_buff_wr == mask) cnt++;
         tick();
         sd_buff_wr = 1'b0;
         tick();
      end
      check($sformatf("buff_wr_count_c%0d", c), 64'(cnt), 64'(nbytes));
      sd_ack = 1'b0;
      tick();
      cl_rd = cl_rd & ~drop_rd;
      cl_wr = cl_wr & ~drop_wr;
      tick();
      check($sformatf("idle_gap_c%0d", c), {sd_rd, sd_wr, busy, sd_buff_din, cl_ack}, 64'd0);
   endtask

   // Monitor: every new grant and every cl_done pulse consumes one expected event.
   initial begin : monitor
      logic prev_req;
      logic [N-1:0] emask;
      ev_t e;
      prev_req = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (reset_n) begin
            if ((sd_rd || sd_wr) && !prev_req) begin
               if (exp_q.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL grant_unexpected: cur=%0d lba=%h", cur, sd_lba);
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("grant_c%0d", e.client), {1'b0, cur, sd_wr, sd_rd, sd_lba},
                        {e.done, 2'(e.client), e.wr, ~e.wr, e.lba});
               end
            end
            if (cl_done != '0) begin
               if (exp_q.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL done_unexpected: cl_done=%b cl_err=%b", cl_done, cl_err);
               end else begin
                  e = exp_q.pop_front();
                  emask = '0;
                  emask[e.client] = 1'b1;
                  check($sformatf("done_c%0d", e.client), {1'b1, cl_done, cl_err},
                        {e.done, emask, e.err ? emask : 3'b000});
               end
            end
            prev_req = sd_rd || sd_wr;
         end else begin
            prev_req = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      int t;
      int cnt;
      reset_n     = 1'b0;
      cl_rd       = '0;
      cl_wr       = '0;
      cl_lba      = {32'h0000_0300, 32'h0000_0200, 32'h0000_0010};
      cl_buff_din = 24'h00_00_00;
      sd_ack      = 1'b0;
      sd_buff_wr  = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      check("reset_outs", {cl_ack, cl_buff_wr, cl_done, cl_err, sd_rd, sd_wr, busy, cur, sd_buff_din},
            64'd0);
      check("reset_lba", 64'(sd_lba), 64'd0);

      // 1: single read, 512-byte sector
      push_grant(0, 1'b0, 32'h10);
      push_done(0, 1'b0);
      cl_rd = 3'b001;
      check("t1_before_grant", {sd_rd, busy}, 64'd0);
      tick();
      check("t1_latency", {sd_rd, sd_wr, sd_lba}, {1'b1, 1'b0, 32'h10});
      hps_xfer(0, 512, 8'h00, 3'b001, 3'b000);

      // 2: simultaneous requests from reset, client 0 re-requests right away
      do_reset();
      cl_buff_din = {8'h33, 8'h22, 8'h11};
      push_grant(0, 1'b0, 32'h10);  push_done(0, 1'b0);
      push_grant(1, 1'b0, 32'h200); push_done(1, 1'b0);
      push_grant(2, 1'b0, 32'h300); push_done(2, 1'b0);
      push_grant(0, 1'b0, 32'h10);  push_done(0, 1'b0);
      cl_rd = 3'b111;
      hps_xfer(0, 4, 8'h11, 3'b000, 3'b000);
      hps_xfer(1, 4, 8'h22, 3'b010, 3'b000);
      hps_xfer(2, 4, 8'h33, 3'b100, 3'b000);
      hps_xfer(0, 4, 8'h11, 3'b001, 3'b000);

      // 3: write routing from client 2
      cl_lba[95:64] = 32'hABCD_0002;
      cl_buff_din   = {8'hA5, 8'h00, 8'h00};
      push_grant(2, 1'b1, 32'hABCD_0002);
      push_done(2, 1'b0);
      cl_wr = 3'b100;
      hps_xfer(2, 8, 8'hA5, 3'b000, 3'b100);

      // 4: read and write both set on client 1: read first, then write
      push_grant(1, 1'b0, 32'h200); push_done(1, 1'b0);
      push_grant(1, 1'b1, 32'h200); push_done(1, 1'b0);
      cl_rd = 3'b010;
      cl_wr = 3'b010;
      hps_xfer(1, 4, 8'h00, 3'b010, 3'b000);
      hps_xfer(1, 4, 8'h00, 3'b000, 3'b010);

      // 5: timeout with sd_ack never rising
      push_grant(1, 1'b0, 32'h200);
      push_done(1, 1'b1);
      cl_rd = 3'b010;
      wait_grant(t);
      cnt = 0;
      while (sd_rd && cnt < 100) begin
         cnt++;
         tick();
      end
      check("timeout_len", 64'(cnt), 64'd16);
      check("timeout_pulse", {cl_done, cl_err, sd_rd, busy}, {3'b010, 3'b010, 1'b0, 1'b0});
      cl_rd = 3'b000;
      tick();
      check("timeout_after", {cl_done, cl_err, busy, sd_rd}, 64'd0);

      // 6: asynchronous reset in the middle of a transfer
      push_grant(2, 1'b0, 32'hABCD_0002);
      cl_rd = 3'b100;
      wait_grant(t);
      tick();
      sd_ack = 1'b1;
      tick();
      check("t6_in_xfer", {cl_ack, busy}, {3'b100, 1'b1});
      #2 reset_n = 1'b0;
      #1;
      check("t6_async_reset",
            {cl_ack, cl_buff_wr, cl_done, cl_err, sd_rd, sd_wr, busy, cur, sd_buff_din, sd_lba}, 64'd0);
      cl_rd = 3'b000;
      tick();
      reset_n = 1'b1;
      tick();
      sd_ack = 1'b0;
      tick();
      tick();
      check("t6_stale_ack_ignored", {busy, cl_done, cl_err, cl_ack}, 64'd0);
      push_grant(0, 1'b0, 32'h10);  push_done(0, 1'b0);
      push_grant(1, 1'b0, 32'h200); push_done(1, 1'b0);
      cl_rd = 3'b011;
      hps_xfer(0, 2, 8'h00, 3'b001, 3'b000);
      hps_xfer(1, 2, 8'h00, 3'b010, 3'b000);

      repeat (5) tick();
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
